rca_16bit: RTL and testbench

- Unsigned 16-bit adder built as an explicit ripple-carry chain of full-adder cells, with a single registered output stage.
- Used as the baseline adder in the datapath: registered operands in, registered sum, carry-out and signed-overflow flag out.
- One-cycle latency with a simple valid pipeline flag so downstream logic knows when results are fresh.

---
 rtl/rca_16bit.sv | 64 ++++++
 tb/tb_rca_16bit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rca_16bit.sv
// Unsigned WIDTH-bit ripple-carry adder: a chain of full-adder cells feeding a
// single output register stage with a valid flag, carry-out and signed overflow.
module rca_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    // One full-adder cell: returns {carry_out, sum_bit}.
    function automatic logic [1:0] fa_cell(input logic ai, input logic bi, input logic ci);
        logic p;
        p = ai ^ bi;
        return {(ai & bi) | (ci & p), p ^ ci};
    endfunction

    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;
    logic             ovf_s;

    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             valid_r;

    assign carry_s[0] = cin;

    // Each stage consumes the carry of the stage below, so the chain ripples LSB to MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign {carry_s[i+1], sum_s[i]} = fa_cell(a[i], b[i], carry_s[i]);
    end

    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign ovf_s = carry_s[WIDTH] ^ carry_s[WIDTH-1];

    // Output stage: captures every cycle; consumers qualify with out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            sum_r   <= sum_s;
            cout_r  <= carry_s[WIDTH];
            ovf_r   <= ovf_s;
            valid_r <= in_valid;
        end
    end

    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    assign out_valid = valid_r;

endmodule

// File: tb/tb_rca_16bit.sv
// Scoreboard bench for rca_16bit: directed corner cases plus random vectors
// checked against an arithmetic reference model with one-cycle latency.
module tb_rca_16bit;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        valid;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        in_valid;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        out_valid;

    int checks = 0;
    int errors = 0;
    exp_t q[$];
    logic mon_rst;

    rca_16bit #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .in_valid (in_valid),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic c, input logic v);
        exp_t e;
        int unsigned total;
        int signed   stotal;
        total  = int'(x) + int'(y) + int'(c);
        stotal = int'($signed(x)) + int'($signed(y)) + int'(c);
        e.sum   = total[15:0];
        e.cout  = (total >= 32'd65536);
        e.ovf   = (stotal > 32767) || (stotal < -32768);
        e.valid = v;
        return e;
    endfunction

    task automatic drive(input logic [15:0] x, input logic [15:0] y,
                         input logic c, input logic v);
        @(negedge clk);
        a        = x;
        b        = y;
        cin      = c;
        in_valid = v;
        q.push_back(model(x, y, c, v));
    endtask

    // Monitor: after each capturing edge, pop the oldest expectation and compare.
    always @(posedge clk) begin
        mon_rst = rst_n;
        #2;
        if (mon_rst && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("out_valid", 32'(out_valid), 32'(e.valid));
            chk("sum",       32'(sum),       32'(e.sum));
            chk("cout",      32'(cout),      32'(e.cout));
            chk("ovf",       32'(ovf),       32'(e.ovf));
        end
    end

    initial begin
        rst_n    = 1'b0;
        a        = 16'hFFFF;
        b        = 16'h0001;
        cin      = 1'b0;
        in_valid = 1'b1;
        #3;
        chk("rst_sum",   32'(sum),       32'd0);
        chk("rst_cout",  32'(cout),      32'd0);
        chk("rst_ovf",   32'(ovf),       32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_sum", 32'(sum), 32'd0);

        // Release at a negedge together with the first stimulus.
        drive(16'd0, 16'd0, 1'b0, 1'b1);
        rst_n = 1'b1;
        drive(16'd40000, 16'd6000,  1'b0, 1'b1);
        drive(16'd17380, 16'd9700,  1'b0, 1'b1);
        drive(16'd5654,  16'd16662, 1'b0, 1'b1);
        drive(16'd65535, 16'd1,     1'b0, 1'b1);
        drive(16'd65535, 16'd65535, 1'b1, 1'b1);
        drive(16'd32767, 16'd1,     1'b0, 1'b1);
        drive(16'd32768, 16'd32768, 1'b0, 1'b1);
        drive(16'hFFFF,  16'h0000,  1'b1, 1'b1);
        drive(16'h8000,  16'h7FFF,  1'b1, 1'b1);
        drive(16'h8000,  16'hFFFF,  1'b0, 1'b1);

        // Valid pattern 1,0,1.
        drive(16'd10, 16'd20, 1'b0, 1'b1);
        drive(16'd30, 16'd40, 1'b0, 1'b0);
        drive(16'd50, 16'd60, 1'b1, 1'b1);

        for (int i = 0; i < 10000; i++) begin
            drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end

        // Reset between two valid inputs.
        drive(16'd1000, 16'd2000, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'd9;
        b        = 16'd9;
        rst_n    = 1'b0;
        #1;
        chk("midrst_sum",   32'(sum),       32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_queue", 32'(q.size()),  32'd0);
        @(posedge clk);
        #1;
        chk("midrst_hold", 32'(sum), 32'd0);
        drive(16'd5, 16'd7, 1'b0, 1'b1);
        rst_n = 1'b1;
        #1;
        chk("pre_capture_sum", 32'(sum), 32'd0);
        @(posedge clk);
        #3;
        chk("post_rst_sum",   32'(sum),       32'd12);
        chk("post_rst_valid", 32'(out_valid), 32'd1);

        repeat (3) @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
